// File: rtl/gray_pack_fifo_ise_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pack_fifo_ise_pkg
// Brief    : Opcodes, status bit positions and defaults for the pixel packer.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pack_fifo_ise_pkg;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'd0,
        OP_POP    = 2'd1,
        OP_STATUS = 2'd2,
        OP_CLEAR  = 2'd3
    } opcode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    localparam int DEF_FIFO_DEPTH = 4;

    localparam int ST_CNT_LSB   = 0;
    localparam int ST_BYTE_LSB  = 4;
    localparam int ST_UNDER_BIT = 8;
    localparam int ST_OVER_BIT  = 9;

endpackage
`default_nettype wire

// File: rtl/gray_pack_fifo_ise_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_pack_fifo_ise_if
// Brief    : Custom-instruction request/response bundle for the pixel packer.
// Revision : 1.0 - initial release
// ============================================================================
interface gray_pack_fifo_ise_if;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  iseId;
    logic        done;
    logic [31:0] result;

    modport master (output start, valueA, valueB, iseId, input done, result);
    modport slave  (input start, valueA, valueB, iseId, output done, result);
endinterface
`default_nettype wire

// File: rtl/gray_pack_fifo_ise_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gray_word_fifo
// Brief    : Small word FIFO with count/full/empty; head word read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module gray_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     clr_i,
    input  wire logic                     wr_en_i,
    input  wire logic [WIDTH-1:0]         wr_data_i,
    input  wire logic                     rd_en_i,
    output logic      [WIDTH-1:0]         rd_data_o,
    output logic      [$clog2(DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign w_do_wr   = wr_en_i && !full_o && !clr_i;
    assign w_do_rd   = rd_en_i && !empty_o && !clr_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is unreachable while count is zero, so it carries no reset.
    always_ff @(posedge clock) begin
        if (w_do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule
`default_nettype wire

// File: rtl/gray_pack_fifo_ise.sv
`default_nettype none
// ============================================================================
// Module   : gray_pack_fifo_ise
// Brief    : Custom instruction packing 8-bit pixels into 32-bit words via a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module gray_pack_fifo_ise
    import gray_pack_fifo_ise_pkg::*;
#(
    parameter logic [7:0] customId   = 8'h0,
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  wire logic             clock,
    input  wire logic             reset,
    gray_pack_fifo_ise_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] pack_q, pack_d;
    logic        under_q, under_d;
    logic        over_q, over_d;
    logic [31:0] result_q, result_d;

    logic          w_accept;
    opcode_e       w_op;
    logic          w_fifo_wr, w_fifo_rd, w_fifo_clr;
    logic [31:0]   w_fifo_rdata;
    logic [CW-1:0] w_fifo_count;
    logic          w_full, w_empty;
    logic [31:0]   w_pack_ins;
    logic [2:0]    w_cnt_after;
    logic          w_unused_bits;

    assign w_op          = opcode_e'(bus.valueB[1:0]);
    assign w_accept      = bus.start && (bus.iseId == customId) && (state_q == S_IDLE);
    assign w_unused_bits = ^{bus.valueA[31:8], bus.valueB[31:2]};
    assign bus.done      = (state_q == S_RESP);
    assign bus.result    = result_q;

    gray_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (w_fifo_clr),
        .wr_en_i   (w_fifo_wr),
        .wr_data_i (w_pack_ins),
        .rd_en_i   (w_fifo_rd),
        .rd_data_o (w_fifo_rdata),
        .count_o   (w_fifo_count),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        under_d     = under_q;
        over_d      = over_q;
        result_d    = '0;
        w_fifo_wr   = 1'b0;
        w_fifo_rd   = 1'b0;
        w_fifo_clr  = 1'b0;
        w_cnt_after = 3'(w_fifo_count);
        w_pack_ins  = pack_q;
        w_pack_ins[8*byte_cnt_q +: 8] = bus.valueA[7:0];

        if (w_accept) begin
            case (w_op)
                OP_PUSH: begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        pack_d     = '0;
                        // A completed word with no room is dropped, not retried.
                        if (w_full) begin
                            over_d = 1'b1;
                        end else begin
                            w_fifo_wr   = 1'b1;
                            w_cnt_after = 3'(w_fifo_count) + 3'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        pack_d     = w_pack_ins;
                    end
                    result_d = {26'b0, byte_cnt_d, 1'b0, w_cnt_after};
                end
                OP_POP: begin
                    if (w_empty) begin
                        under_d = 1'b1;
                    end else begin
                        w_fifo_rd = 1'b1;
                        result_d  = w_fifo_rdata;
                    end
                end
                OP_STATUS: begin
                    result_d[ST_CNT_LSB +: 3]  = 3'(w_fifo_count);
                    result_d[ST_BYTE_LSB +: 2] = byte_cnt_q;
                    result_d[ST_UNDER_BIT]     = under_q;
                    result_d[ST_OVER_BIT]      = over_q;
                    under_d = 1'b0;
                    over_d  = 1'b0;
                end
                default: begin
                    w_fifo_clr = 1'b1;
                    byte_cnt_d = 2'd0;
                    pack_d     = '0;
                    under_d    = 1'b0;
                    over_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            pack_q     <= '0;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            under_q    <= under_d;
            over_q     <= over_d;
            result_q   <= result_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gray_pack_fifo_ise.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_pack_fifo_ise
// Brief    : Self-checking bench for gray_pack_fifo_ise with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_pack_fifo_ise;
    import gray_pack_fifo_ise_pkg::*;

    localparam logic [7:0] CID = 8'h5A;
    localparam logic [7:0] BAD = 8'hA5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    gray_pack_fifo_ise_if bus();

    gray_pack_fifo_ise #(.customId(CID), .FIFO_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending pixels and stored words kept as plain queues.
    bit [7:0]  m_pend[$];
    bit [31:0] m_q[$];
    bit        m_ovf, m_unf;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  px;
        logic [7:0]  id;
        logic        exp_done;
        logic [31:0] exp_res;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend.delete();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [31:0] model_op(input logic [1:0] op, input logic [7:0] px);
        logic [31:0] r;
        logic [31:0] w;
        r = '0;
        case (op)
            2'd0: begin
                m_pend.push_back(px);
                if (m_pend.size() == 4) begin
                    w = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
                    if (m_q.size() < 4) m_q.push_back(w);
                    else m_ovf = 1'b1;
                    m_pend.delete();
                end
                r = {26'b0, 2'(m_pend.size()), 1'b0, 3'(m_q.size())};
            end
            2'd1: begin
                if (m_q.size() > 0) r = m_q.pop_front();
                else m_unf = 1'b1;
            end
            2'd2: begin
                r = {22'b0, m_ovf, m_unf, 2'b00, 2'(m_pend.size()), 1'b0, 3'(m_q.size())};
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            default: model_reset();
        endcase
        return r;
    endfunction

    // One request: start driven for exactly one edge, outputs sampled in the cycle after.
    task automatic op_chk(input string name, input logic [1:0] op, input logic [7:0] px,
                          input logic [7:0] id, input logic exp_d, input logic [31:0] exp_r);
        @(negedge clock);
        chk({name, "_pre_done"}, {31'b0, bus.done}, 32'd0);
        bus.start  = 1'b1;
        bus.valueA = {24'($urandom), px};
        bus.valueB = {30'($urandom), op};
        bus.iseId  = id;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk({name, "_done"}, {31'b0, bus.done}, {31'b0, exp_d});
        chk({name, "_result"}, bus.result, exp_r);
        @(posedge clock);
        #1;
        chk({name, "_done_after"}, {31'b0, bus.done}, 32'd0);
        chk({name, "_result_after"}, bus.result, 32'd0);
    endtask

    task automatic op_model(input string name, input logic [1:0] op, input logic [7:0] px);
        logic [31:0] e;
        e = model_op(op, px);
        op_chk(name, op, px, CID, 1'b1, e);
    endtask

    initial begin
        logic [31:0] e;
        int          r;
        logic [7:0]  id;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.valueA = '0;
        bus.valueB = '0;
        bus.iseId  = '0;
        model_reset();

        tbl[0] = '{2'd0, 8'h11, CID, 1'b1, 32'h0000_0010};
        tbl[1] = '{2'd0, 8'h22, CID, 1'b1, 32'h0000_0020};
        tbl[2] = '{2'd0, 8'h33, CID, 1'b1, 32'h0000_0030};
        tbl[3] = '{2'd0, 8'h44, CID, 1'b1, 32'h0000_0001};
        tbl[4] = '{2'd1, 8'h00, CID, 1'b1, 32'h4433_2211};
        tbl[5] = '{2'd1, 8'h00, BAD, 1'b0, 32'h0000_0000};
        tbl[6] = '{2'd2, 8'h00, CID, 1'b1, 32'h0000_0000};

        repeat (3) @(negedge clock);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].id == CID) e = model_op(tbl[i].op, tbl[i].px);
            op_chk($sformatf("tbl%0d", i), tbl[i].op, tbl[i].px, tbl[i].id,
                   tbl[i].exp_done, tbl[i].exp_res);
        end

        // Overflow: five words pushed into a four-deep buffer.
        for (int i = 1; i <= 20; i++) op_model("ovf_push", 2'd0, 8'(i));
        op_chk("ovf_status", 2'd2, 8'h00, CID, 1'b1, 32'h0000_0204);
        e = model_op(2'd2, 8'h00);
        op_chk("ovf_status2", 2'd2, 8'h00, CID, 1'b1, 32'h0000_0004);
        e = model_op(2'd2, 8'h00);
        for (int i = 0; i < 4; i++) op_model("ovf_pop", 2'd1, 8'h00);
        op_model("unf_pop", 2'd1, 8'h00);
        op_chk("unf_status", 2'd2, 8'h00, CID, 1'b1, 32'h0000_0100);
        e = model_op(2'd2, 8'h00);

        // Start held into the response cycle must be ignored.
        op_model("hold_push0", 2'd0, 8'h55);
        @(negedge clock);
        e = model_op(2'd0, 8'h66);
        bus.start  = 1'b1;
        bus.valueA = 32'h0000_0066;
        bus.valueB = 32'h0000_0000;
        bus.iseId  = CID;
        @(posedge clock);
        #1;
        chk("hold_done", {31'b0, bus.done}, 32'd1);
        chk("hold_result", bus.result, e);
        bus.valueA = 32'h0000_0077;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("hold_ignored_done", {31'b0, bus.done}, 32'd0);
        chk("hold_ignored_result", bus.result, 32'd0);
        @(posedge clock);
        #1;
        chk("hold_idle_done", {31'b0, bus.done}, 32'd0);
        op_chk("hold_status", 2'd2, 8'h00, CID, 1'b1, 32'h0000_0020);
        e = model_op(2'd2, 8'h00);

        // Foreign instruction IDs never respond and never change state.
        op_chk("badid_push", 2'd0, 8'h99, BAD, 1'b0, 32'd0);
        op_chk("badid_clear", 2'd3, 8'h00, 8'h00, 1'b0, 32'd0);
        op_chk("badid_pop", 2'd1, 8'h00, BAD, 1'b0, 32'd0);
        op_chk("badid_status", 2'd2, 8'h00, CID, 1'b1, 32'h0000_0020);
        e = model_op(2'd2, 8'h00);

        // Clear discards partial pixels.
        for (int i = 0; i < 3; i++) op_model("clr_push", 2'd0, 8'(8'hC0 + i));
        op_chk("clr_clear", 2'd3, 8'h00, CID, 1'b1, 32'd0);
        e = model_op(2'd3, 8'h00);
        op_chk("clr_status", 2'd2, 8'h00, CID, 1'b1, 32'd0);
        e = model_op(2'd2, 8'h00);
        for (int i = 0; i < 4; i++) op_model("aa_push", 2'd0, 8'hAA);
        op_chk("aa_pop", 2'd1, 8'h00, CID, 1'b1, 32'hAAAA_AAAA);
        e = model_op(2'd1, 8'h00);

        // Reset asserted in the response cycle of a POP.
        for (int i = 0; i < 4; i++) op_model("rst_push", 2'd0, 8'(8'h10 * (i + 1)));
        @(negedge clock);
        bus.start  = 1'b1;
        bus.valueA = '0;
        bus.valueB = 32'h0000_0001;
        bus.iseId  = CID;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("rst_pop_done", {31'b0, bus.done}, 32'd1);
        chk("rst_pop_result", bus.result, 32'h4030_2010);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_done", {31'b0, bus.done}, 32'd0);
        chk("rst_async_result", bus.result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_no_late_done", {31'b0, bus.done}, 32'd0);
        op_chk("rst_status", 2'd2, 8'h00, CID, 1'b1, 32'd0);
        e = model_op(2'd2, 8'h00);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            id = ($urandom_range(0, 9) == 0) ? BAD : CID;
            if (r < 10) begin
                e = 8'($urandom);
                if (id == CID) op_model("rand_push", 2'd0, e[7:0]);
                else op_chk("rand_bad", 2'd0, e[7:0], id, 1'b0, 32'd0);
            end else begin
                e = (r < 16) ? 32'd1 : (r < 19) ? 32'd2 : 32'd3;
                if (id == CID) op_model("rand_op", e[1:0], 8'($urandom));
                else op_chk("rand_bad", e[1:0], 8'($urandom), id, 1'b0, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
